// File: rtl/calc_operand_sequencer_pkg.sv
// rtl/calc_operand_sequencer_pkg.sv - shared types and widths for the calculator input stage
package calc_pkg;

  localparam int DATA_W = 4;

  // Calculator opcodes, entered on sw[1:0]
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_OR  = 2'b10,
    OP_EQ  = 2'b11
  } op_e;

  // Entry sequencer states; the encoding is exported on the phase LEDs
  typedef enum logic [1:0] {
    S_ENTER_A  = 2'd0,
    S_ENTER_B  = 2'd1,
    S_ENTER_OP = 2'd2,
    S_ISSUE    = 2'd3
  } phase_e;

endpackage

// File: rtl/calc_operand_sequencer_if.sv
// rtl/calc_operand_sequencer_if.sv - switch/button inputs and issued operand bundle
interface calc_operand_sequencer_if;
  import calc_pkg::*;

  logic [DATA_W-1:0] sw;
  logic              btn_enter_raw;
  logic              btn_clear_raw;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  op_e               op;
  logic              issue;
  logic [1:0]        phase;

  // The sequencer consumes switches/buttons and produces the bundle
  modport slave (
    input  sw, btn_enter_raw, btn_clear_raw,
    output a, b, op, issue, phase
  );

  // The board / environment side drives switches and buttons
  modport master (
    output sw, btn_enter_raw, btn_clear_raw,
    input  a, b, op, issue, phase
  );

endinterface

// File: rtl/calc_debouncer.sv
// rtl/calc_debouncer.sv - 2-flop synchronizer, counter debouncer and rising-edge press pulse
module calc_debouncer #(
  parameter int  DEBOUNCE_CYCLES = 16,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             deb_q, deb_d;
  logic             deb_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s;

  assign s = sync_q[1];

  // Accept a new level only after it has differed from deb for DEBOUNCE_CYCLES cycles
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = s;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounced level, its one-cycle delay and the stability counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= {sync_q[0], raw_i};
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  // One pulse per accepted rising level; releases produce nothing
  assign press_o = deb_q & ~deb_prev_q;

endmodule

// File: rtl/calc_operand_sequencer.sv
// rtl/calc_operand_sequencer.sv - collects A, B and opcode from shared switches and issues a bundle
module calc_operand_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  calc_operand_sequencer_if.slave  bus
);

  logic enter_press, clear_press;

  calc_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enter (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (bus.btn_enter_raw),
    .press_o (enter_press)
  );

  calc_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (bus.btn_clear_raw),
    .press_o (clear_press)
  );

  phase_e            state_q, state_d;
  logic              clr_pend_q, clr_pend_d;
  logic [DATA_W-1:0] a_stg_q, b_stg_q;
  op_e               op_stg_q;
  logic [DATA_W-1:0] a_q, b_q;
  op_e               op_q;
  logic              issue_q;

  logic clear_evt;
  logic cap_a, cap_b, cap_op, zero_stg, do_issue;

  // A clear arriving during S_ISSUE is parked and applied on the next cycle
  assign clear_evt = clear_press | clr_pend_q;

  // State register plus the parked-clear flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_ENTER_A;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  // Next state: clear beats enter; S_ISSUE always returns to S_ENTER_A
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ISSUE:    state_d = S_ENTER_A;
      S_ENTER_A:  if (clear_evt) state_d = S_ENTER_A;
                  else if (enter_press) state_d = S_ENTER_B;
      S_ENTER_B:  if (clear_evt) state_d = S_ENTER_A;
                  else if (enter_press) state_d = S_ENTER_OP;
      S_ENTER_OP: if (clear_evt) state_d = S_ENTER_A;
                  else if (enter_press) state_d = S_ISSUE;
      default:    state_d = S_ENTER_A;
    endcase
  end

  // Per-state datapath controls
  always_comb begin
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    cap_op     = 1'b0;
    zero_stg   = 1'b0;
    do_issue   = 1'b0;
    clr_pend_d = 1'b0;
    if (state_q == S_ISSUE) begin
      do_issue   = 1'b1;
      clr_pend_d = clear_press;
    end else if (clear_evt) begin
      zero_stg = 1'b1;
    end else if (enter_press) begin
      cap_a  = (state_q == S_ENTER_A);
      cap_b  = (state_q == S_ENTER_B);
      cap_op = (state_q == S_ENTER_OP);
    end
  end

  // Staging registers fill one field per ENTER and are wiped by CLEAR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_stg_q  <= '0;
      b_stg_q  <= '0;
      op_stg_q <= OP_ADD;
    end else if (zero_stg) begin
      a_stg_q  <= '0;
      b_stg_q  <= '0;
      op_stg_q <= OP_ADD;
    end else begin
      if (cap_a)  a_stg_q  <= bus.sw;
      if (cap_b)  b_stg_q  <= bus.sw;
      if (cap_op) op_stg_q <= op_e'(bus.sw[1:0]);
    end
  end

  // Output bundle only changes together with the issue strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      issue_q <= 1'b0;
    end else begin
      issue_q <= do_issue;
      if (do_issue) begin
        a_q  <= a_stg_q;
        b_q  <= b_stg_q;
        op_q <= op_stg_q;
      end
    end
  end

  assign bus.a     = a_q;
  assign bus.b     = b_q;
  assign bus.op    = op_q;
  assign bus.issue = issue_q;
  assign bus.phase = state_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// tb/tb_calc_operand_sequencer.sv - scoreboard bench for the calculator operand sequencer
module tb_calc_operand_sequencer;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  calc_operand_sequencer_if bus();

  calc_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: entry progress, staged fields and last issued bundle
  int         mph = 0;
  logic [3:0] ma = 0, mb = 0;
  logic [9:0] mlast = 0;
  logic [9:0] exp_q[$];

  int         issue_cnt = 0;
  int         issue_cyc = 0;
  int         rise_cyc  = 0;
  logic [1:0] last_ph   = 0;
  logic [1:0] ph_log[$];

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Monitor: every issue pulse must match the oldest expected bundle
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.issue === 1'b1) begin
      issue_cnt++;
      issue_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got bundle %h expected none", {bus.a, bus.b, bus.op});
      end else begin
        chk("issue_bundle", int'({bus.a, bus.b, bus.op}), int'(exp_q.pop_front()));
      end
    end
    if (bus.phase !== last_ph) begin
      ph_log.push_back(bus.phase);
      last_ph = bus.phase;
    end
  end

  function automatic void model_enter(logic [3:0] v);
    case (mph)
      0: begin ma = v; mph = 1; end
      1: begin mb = v; mph = 2; end
      default: begin
        mlast = {ma, mb, v[1:0]};
        exp_q.push_back(mlast);
        mph = 0;
      end
    endcase
  endfunction

  function automatic void model_clear();
    mph = 0;
    ma  = 0;
    mb  = 0;
  endfunction

  task automatic post_check();
    chk("phase", int'(bus.phase), mph);
    chk("hold_bundle", int'({bus.a, bus.b, bus.op}), int'(mlast));
  endtask

  task automatic press(bit en, bit cl, logic [3:0] v, int hold, int gap);
    @(negedge clk);
    if (cl) model_clear();
    else if (en) model_enter(v);
    bus.sw = v;
    bus.btn_enter_raw = en;
    bus.btn_clear_raw = cl;
    rise_cyc = cyc;
    repeat (hold) @(negedge clk);
    bus.btn_enter_raw = 1'b0;
    bus.btn_clear_raw = 1'b0;
    repeat (gap) @(negedge clk);
    post_check();
  endtask

  initial begin
    int base;
    bus.sw = 0;
    bus.btn_enter_raw = 0;
    bus.btn_clear_raw = 0;
    rst_n = 1'b1;

    // Reset asserted between edges acts immediately
    #3 rst_n = 1'b0;
    #1;
    chk("rst_bundle", int'({bus.a, bus.b, bus.op}), 0);
    chk("rst_issue", int'(bus.issue), 0);
    chk("rst_phase", int'(bus.phase), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_no_issue", issue_cnt, 0);
    chk("idle_phase", int'(bus.phase), 0);

    // Full entry 3,5,SUB with phase sequence and latency
    ph_log.delete();
    press(1, 0, 4'd3, 10, 10);
    press(1, 0, 4'd5, 10, 10);
    press(1, 0, 4'd1, 10, 10);
    chk("full_issue_count", issue_cnt, 1);
    chk("full_latency", issue_cyc - rise_cyc, 8);
    chk("full_phase_len", ph_log.size(), 4);
    for (int i = 0; i < 4 && i < ph_log.size(); i++)
      chk("full_phase_seq", int'(ph_log[i]), (i + 1) % 4);

    // Bounce shorter than the debounce window is rejected
    base = issue_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.btn_enter_raw = (i % 2 == 0);
    end
    @(negedge clk);
    bus.btn_enter_raw = 1'b0;
    repeat (20) @(negedge clk);
    chk("bounce_phase", int'(bus.phase), 0);
    chk("bounce_no_issue", issue_cnt, base);
    press(1, 0, 4'd6, 10, 10);
    chk("bounce_then_press", int'(bus.phase), 1);
    press(0, 1, 4'd0, 10, 10);

    // Clear aborts entry and leaves the outputs alone
    press(1, 0, 4'd7, 10, 10);
    press(1, 0, 4'd2, 10, 10);
    press(0, 1, 4'd2, 10, 10);
    press(1, 0, 4'd1, 10, 10);
    press(1, 0, 4'd1, 10, 10);
    press(1, 0, 4'd3, 10, 10);

    // Simultaneous ENTER and CLEAR in S_ENTER_B: clear wins
    press(1, 0, 4'd8, 10, 10);
    base = issue_cnt;
    press(1, 1, 4'hA, 10, 10);
    chk("simul_no_issue", issue_cnt, base);

    // Asynchronous reset mid-entry
    press(1, 0, 4'd9, 10, 10);
    press(1, 0, 4'd4, 10, 10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_bundle", int'({bus.a, bus.b, bus.op}), 0);
    chk("midrst_phase", int'(bus.phase), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    mlast = 0;
    repeat (10) @(negedge clk);
    post_check();
    press(1, 0, 4'd9, 10, 10);
    press(1, 0, 4'd4, 10, 10);
    press(1, 0, 4'd2, 10, 10);

    // Randomized entry with occasional clears
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0)
        press(0, 1, 4'($urandom_range(0, 15)), $urandom_range(8, 12), $urandom_range(8, 12));
      else
        press(1, 0, 4'($urandom_range(0, 15)), $urandom_range(8, 12), $urandom_range(8, 12));
    end

    repeat (20) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_operand_sequencer.md
Name: calc_operand_sequencer

Overview:
Upstream input stage for the 4-bit calculator. Collects operand A, operand B and opcode from one shared 4-bit switch bank using a debounced ENTER button. A debounced CLEAR button aborts entry. Presents a stable {a, b, op} bundle plus a one-cycle issue strobe to the calculator datapath.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required before a button level change is accepted; legal range 2..65535.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, never overridden.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
sw  in  4  data switches; operand value, or opcode on sw[1:0]
btn_enter_raw  in  1  raw asynchronous ENTER button, active-high
btn_clear_raw  in  1  raw asynchronous CLEAR button, active-high
a  out  4  latched operand A
b  out  4  latched operand B
op  out  2  latched opcode (calc_pkg::op_e)
issue  out  1  one-cycle strobe: {a, b, op} is a new complete bundle
phase  out  2  current FSM state encoding, for status LEDs

Behaviour:
- Reset (rst_n low, asynchronous): a=0, b=0, op=OP_ADD, issue=0, phase=S_ENTER_A. All synchronizer, debounce and counter flops are cleared, and pending staging registers are cleared.
- Synchronizer: 2-flop chain per button; synced level s lags raw by 2 edges.
- Debouncer, per button: level deb and counter cnt.
  - Any cycle where s==deb: cnt<=0.
  - Any cycle where s!=deb: cnt increments.
  - When cnt==DEBOUNCE_CYCLES-1 and s!=deb: deb<=s and cnt<=0.
  - Net effect: deb follows a clean raw level change DEBOUNCE_CYCLES+2 edges after raw changes. A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no change.
  - press = deb & ~deb_d, where deb_d is deb delayed by 1 flop. press is high for exactly one cycle per accepted rising level. Falling levels generate no event.
- FSM states, from calc_pkg::phase_e: S_ENTER_A=0, S_ENTER_B=1, S_ENTER_OP=2, S_ISSUE=3.
  - S_ENTER_A, on enter press: a_stg<=sw; go to S_ENTER_B.
  - S_ENTER_B, on enter press: b_stg<=sw; go to S_ENTER_OP.
  - S_ENTER_OP, on enter press: op_stg<=sw[1:0]; go to S_ISSUE.
  - S_ISSUE: lasts exactly one cycle; copy a<=a_stg, b<=b_stg, op<=op_stg; issue<=1 on that edge; go to S_ENTER_A unconditionally.
  - issue is therefore registered: it is high in the cycle after S_ISSUE, coinciding with the new a/b/op values.
- Outputs a, b, op change only on an issue edge. They hold the last issued bundle during entry, so the downstream register always sees a consistent bundle.
- Clear press, in any state except S_ISSUE: go to S_ENTER_A and zero the staging registers. a, b and op are unchanged.
- Clear press in S_ISSUE: the issue completes first. The clear is not lost; it is applied in S_ENTER_A, where it re-zeroes staging.
- Enter and clear press in the same cycle: clear wins; the enter press is discarded.
- Enter press while in S_ISSUE: ignored. This is unreachable after debouncing, but must be handled safely.
- sw is sampled directly without synchronization. The user holds the switches static across ENTER.
- phase encodes the present state. It is never X after reset.

Decomposition:
- calc_pkg holds:
  - op_e: OP_ADD=2'b00, OP_SUB=2'b01, OP_OR=2'b10, OP_EQ=2'b11
  - phase_e: 2-bit encoding as listed above
  - DATA_W=4
- Sub-module calc_debouncer, parameterized by DEBOUNCE_CYCLES, instantiated twice (enter, clear). It contains the synchronizer, counter, deb/deb_d flops and press output.
- The FSM and staging registers live in the top module.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: rst_n low mid-clock, with no edge -> all outputs 0, phase=0 immediately. Release, hold buttons low 20 cycles -> issue never asserts.
- Full entry:
  - Stimulus: sw=3 + ENTER, sw=5 + ENTER, sw=1 (SUB) + ENTER. Each press is held 10 cycles, with 10 cycles released between presses.
  - Required: exactly one issue pulse; with it a=3, b=5, op=01; phase sequence 0,1,2,3,0.
  - Required latency: 4+2+1+1 edges from the third raw rise to issue, counted as debounce+sync, press register, then S_ISSUE.
- Bounce rejection: ENTER raw toggles 1,0,1,0 with 1-cycle pulses, then stays low -> no press, phase stays 0. A later stable 10-cycle press -> phase=1.
- Clear abort: enter A=7, enter B=2, then CLEAR -> phase=0, a/b/op still hold the previous bundle. A fresh entry of 1,1,OP_EQ -> issue with a=1, b=1, op=11.
- Simultaneous: ENTER and CLEAR raw rise on the same cycle while in S_ENTER_B -> phase=0, b_stg not captured, no issue.
- Reset mid-operation: reach S_ENTER_OP, assert rst_n low for 1 cycle -> phase=0, outputs 0. A full entry then works normally with no spurious press from stale debounce state.
